// File: rtl/pipeline_pkg.sv
// Shared MEM-stage types: load/store kind decoded in ID and the data-memory FSM states.
package pipeline_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } sl_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_store_align.sv
// Byte-lane steering for stores plus alignment checking for every load/store kind.
module mem_store_align
    import pipeline_pkg::*;
(
    input  logic [3:0]  sl_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    sl_type_t slType;
    assign slType = sl_type_t'(sl_type_i);

    // Store data is replicated across lanes so the strobe alone selects the target bytes.
    always_comb begin
        wstrb_o    = 4'b0000;
        wdata_o    = data_i;
        misalign_o = 1'b0;
        case (slType)
            SB: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{data_i[7:0]}};
            end
            SH: begin
                wstrb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{data_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            SW: begin
                wstrb_o    = 4'b1111;
                misalign_o = (addr_lo_i != 2'b00);
            end
            LH, LHU: misalign_o = addr_lo_i[0];
            LW:      misalign_o = (addr_lo_i != 2'b00);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: drives the req/gnt/rvalid bus, stalls the pipe and
// registers the raw load word for MEM/WB.
module mem_access_unit
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [3:0]  sl_type_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_wstrb_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        mem_stall_o,
    output logic [31:0] dram_data_o,
    output logic        misalign_o,
    output logic        access_fault_o
);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dram_q, dram_d;
    logic             fault_q, fault_d;

    logic        memOp;
    logic        go;
    logic        alignMis;
    logic        timeoutHit;
    logic [3:0]  laneStrb;
    logic [31:0] laneData;

    mem_store_align u_align (
        .sl_type_i  (sl_type_i),
        .addr_lo_i  (addr_i[1:0]),
        .data_i     (store_data_i),
        .wstrb_o    (laneStrb),
        .wdata_o    (laneData),
        .misalign_o (alignMis)
    );

    assign memOp      = instr_valid_i & (mem_re_i | mem_we_i);
    assign misalign_o = memOp & alignMis;
    assign go         = memOp & ~alignMis;
    assign timeoutHit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Bus fields come straight from the stalled EX/MEM register, so they stay stable while in REQ.
    assign dbus_req_o     = ((state_q == IDLE) & go) | (state_q == REQ);
    assign dbus_we_o      = mem_we_i;
    assign dbus_addr_o    = {addr_i[31:2], 2'b00};
    assign dbus_wstrb_o   = mem_we_i ? laneStrb : 4'b0000;
    assign dbus_wdata_o   = laneData;
    assign mem_stall_o    = go & (state_q != DONE);
    assign dram_data_o    = dram_q;
    assign access_fault_o = fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dram_d  = dram_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    cnt_d = '0;
                    if (dbus_gnt_i) begin
                        state_d = mem_we_i ? DONE : WAIT_R;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (dbus_gnt_i) begin
                    state_d = mem_we_i ? DONE : WAIT_R;
                end else if (timeoutHit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    dram_d  = '0;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + 1'b1;
                if (dbus_rvalid_i) begin
                    state_d = DONE;
                    dram_d  = dbus_rdata_i;
                end else if (timeoutHit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    dram_d  = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dram_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dram_q  <= dram_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle vector table plus multi-cycle bus sequences.
module tb_mem_access_unit;
    import pipeline_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk, rst;
    logic        instrValid, memRe, memWe;
    logic [3:0]  slType;
    logic [31:0] addr, storeData;
    logic        req, busWe;
    logic [31:0] busAddr, wdata;
    logic [3:0]  wstrb;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        stall, misalign, fault;
    logic [31:0] dramData;

    int nAssert = 0;
    int nFail   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid_i  (instrValid),
        .mem_re_i       (memRe),
        .mem_we_i       (memWe),
        .sl_type_i      (slType),
        .addr_i         (addr),
        .store_data_i   (storeData),
        .dbus_req_o     (req),
        .dbus_we_o      (busWe),
        .dbus_addr_o    (busAddr),
        .dbus_wstrb_o   (wstrb),
        .dbus_wdata_o   (wdata),
        .dbus_gnt_i     (gnt),
        .dbus_rvalid_i  (rvalid),
        .dbus_rdata_i   (rdata),
        .mem_stall_o    (stall),
        .dram_data_o    (dramData),
        .misalign_o     (misalign),
        .access_fault_o (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic        re;
        logic        we;
        logic [3:0]  sl;
        logic [31:0] a;
        logic [31:0] d;
        logic        expReq;
        logic        expStall;
        logic        expMis;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkCore(input string tag, input logic eReq, input logic eStall,
                             input logic eFault, input logic [31:0] eDram);
        checkOutput({tag, ".req"}, {31'd0, req}, {31'd0, eReq});
        checkOutput({tag, ".stall"}, {31'd0, stall}, {31'd0, eStall});
        checkOutput({tag, ".fault"}, {31'd0, fault}, {31'd0, eFault});
        checkOutput({tag, ".dram"}, dramData, eDram);
    endtask

    // Drives a full input set just after the falling edge, then waits 1 unit before checks.
    task automatic applyStimulus(input logic v, input logic re, input logic we, input logic [3:0] sl,
                                 input logic [31:0] a, input logic [31:0] d, input logic g,
                                 input logic rv, input logic [31:0] rd);
        @(negedge clk);
        instrValid = v;
        memRe      = re;
        memWe      = we;
        slType     = sl;
        addr       = a;
        storeData  = d;
        gnt        = g;
        rvalid     = rv;
        rdata      = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        instrValid = 0; memRe = 0; memWe = 0; slType = 4'd0;
        addr = '0; storeData = '0; gnt = 0; rvalid = 0; rdata = '0;

        vecs[0]  = '{1, 0, 1, SB,   32'h203, 32'h1234565A, 1, 1, 0, 4'b1000, 32'h5A5A5A5A};
        vecs[1]  = '{1, 0, 1, SB,   32'h200, 32'h000000C3, 1, 1, 0, 4'b0001, 32'hC3C3C3C3};
        vecs[2]  = '{1, 0, 1, SB,   32'h201, 32'h00000077, 1, 1, 0, 4'b0010, 32'h77777777};
        vecs[3]  = '{1, 0, 1, SH,   32'h102, 32'hAAAABEEF, 1, 1, 0, 4'b1100, 32'hBEEFBEEF};
        vecs[4]  = '{1, 0, 1, SH,   32'h100, 32'h00001234, 1, 1, 0, 4'b0011, 32'h12341234};
        vecs[5]  = '{1, 0, 1, SH,   32'h101, 32'h00001234, 0, 0, 1, 4'b0000, 32'h0};
        vecs[6]  = '{1, 0, 1, SW,   32'h104, 32'hCAFEF00D, 1, 1, 0, 4'b1111, 32'hCAFEF00D};
        vecs[7]  = '{1, 0, 1, SW,   32'h106, 32'hCAFEF00D, 0, 0, 1, 4'b0000, 32'h0};
        vecs[8]  = '{1, 1, 0, LW,   32'h100, 32'h0,        1, 1, 0, 4'b0000, 32'h0};
        vecs[9]  = '{1, 1, 0, LW,   32'h102, 32'h0,        0, 0, 1, 4'b0000, 32'h0};
        vecs[10] = '{1, 1, 0, LHU,  32'h105, 32'h0,        0, 0, 1, 4'b0000, 32'h0};
        vecs[11] = '{1, 1, 0, LB,   32'h103, 32'h0,        1, 1, 0, 4'b0000, 32'h0};
        vecs[12] = '{0, 0, 1, SW,   32'h106, 32'h0,        0, 0, 0, 4'b0000, 32'h0};
        vecs[13] = '{1, 0, 0, NONE, 32'h101, 32'h0,        0, 0, 0, 4'b0000, 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkCore("reset", 0, 0, 0, 32'h0);
        checkOutput("reset.misalign", {31'd0, misalign}, 32'd0);

        // Single-cycle checks in IDLE; the instruction is dropped before the next rising edge.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].re, vecs[i].we, vecs[i].sl, vecs[i].a, vecs[i].d,
                          1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d.req", i), {31'd0, req}, {31'd0, vecs[i].expReq});
            checkOutput($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].expStall});
            checkOutput($sformatf("vec%0d.misalign", i), {31'd0, misalign}, {31'd0, vecs[i].expMis});
            if (vecs[i].expReq) begin
                checkOutput($sformatf("vec%0d.addr", i), busAddr, {vecs[i].a[31:2], 2'b00});
                checkOutput($sformatf("vec%0d.strb", i), {28'd0, wstrb}, {28'd0, vecs[i].expStrb});
                checkOutput($sformatf("vec%0d.we", i), {31'd0, busWe}, {31'd0, vecs[i].we});
                if (vecs[i].we)
                    checkOutput($sformatf("vec%0d.wdata", i), wdata, vecs[i].expWdata);
            end
            instrValid = 1'b0;
        end

        // LW with gnt at once and rvalid one cycle later.
        applyStimulus(1, 1, 0, LW, 32'h100, 0, 1, 0, 32'h0);
        checkCore("lwA0", 1, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, LW, 32'h100, 0, 0, 1, 32'hDEADBEEF);
        checkCore("lwA1", 0, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, LW, 32'h100, 0, 0, 0, 32'h0);
        checkCore("lwA2", 0, 0, 0, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, NONE, 32'h0, 0, 0, 0, 32'h0);
        checkCore("lwA3", 0, 0, 0, 32'hDEADBEEF);

        // Reset while waiting for read data.
        applyStimulus(1, 1, 0, LW, 32'h108, 0, 1, 0, 32'h0);
        checkCore("rstW0", 1, 1, 0, 32'hDEADBEEF);
        applyStimulus(1, 1, 0, LW, 32'h108, 0, 0, 0, 32'h0);
        checkCore("rstW1", 0, 1, 0, 32'hDEADBEEF);
        rst = 1'b1;
        applyStimulus(1, 1, 0, LW, 32'h108, 0, 0, 0, 32'h0);
        rst = 1'b0;
        checkCore("rstW2", 1, 1, 0, 32'h0);
        instrValid = 1'b0;

        // Back-to-back SW then LW; gnt held high through DONE must not trigger a request.
        applyStimulus(1, 0, 1, SW, 32'h300, 32'h11223344, 1, 0, 32'h0);
        checkCore("b2b0", 1, 1, 0, 32'h0);
        checkOutput("b2b0.strb", {28'd0, wstrb}, 32'hF);
        checkOutput("b2b0.wdata", wdata, 32'h11223344);
        applyStimulus(1, 0, 1, SW, 32'h300, 32'h11223344, 1, 0, 32'h0);
        checkCore("b2b1", 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, LW, 32'h304, 0, 1, 0, 32'h0);
        checkCore("b2b2", 1, 1, 0, 32'h0);
        checkOutput("b2b2.strb", {28'd0, wstrb}, 32'h0);
        checkOutput("b2b2.addr", busAddr, 32'h304);
        applyStimulus(1, 1, 0, LW, 32'h304, 0, 0, 1, 32'h0BADF00D);
        checkCore("b2b3", 0, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, LW, 32'h304, 0, 0, 0, 32'h0);
        checkCore("b2b4", 0, 0, 0, 32'h0BADF00D);

        // SB with gnt delayed three cycles: request held for four cycles.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 0, 1, SB, 32'h203, 32'h5A, (c == 3), 0, 32'h0);
            checkCore($sformatf("sbD%0d", c), 1, 1, 0, 32'h0BADF00D);
            checkOutput($sformatf("sbD%0d.strb", c), {28'd0, wstrb}, 32'h8);
            checkOutput($sformatf("sbD%0d.wdata", c), wdata, 32'h5A5A5A5A);
            checkOutput($sformatf("sbD%0d.addr", c), busAddr, 32'h200);
        end
        applyStimulus(1, 0, 1, SB, 32'h203, 32'h5A, 0, 0, 32'h0);
        checkCore("sbD4", 0, 0, 0, 32'h0BADF00D);

        // LW whose read data never arrives: four WAIT_R cycles then a faulting DONE.
        applyStimulus(1, 1, 0, LW, 32'h110, 0, 1, 0, 32'h0);
        checkCore("tmo0", 1, 1, 0, 32'h0BADF00D);
        for (int c = 1; c <= TIMEOUT; c++) begin
            applyStimulus(1, 1, 0, LW, 32'h110, 0, 0, 0, 32'h0);
            checkCore($sformatf("tmo%0d", c), 0, 1, 0, 32'h0BADF00D);
        end
        applyStimulus(1, 1, 0, LW, 32'h110, 0, 0, 0, 32'h0);
        checkCore("tmoDone", 0, 0, 1, 32'h0);
        applyStimulus(0, 0, 0, NONE, 32'h0, 0, 0, 1, 32'h11111111);
        checkCore("tmoLate0", 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, NONE, 32'h0, 0, 0, 0, 32'h0);
        checkCore("tmoLate1", 0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
